// File: rtl/serializador_operandos_if.sv
// Handshake bundle between the operand source, the serializer and the serial adder.
interface serializador_operandos_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_ready;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             bit_first;
    logic             bit_last;
    logic             busy;
    logic [7:0]       word_count;

    // Drives operands and consumes bit pairs (source plus adder side).
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, bit_valid, a_bit, b_bit, bit_first, bit_last, busy, word_count
    );

    // The serializer itself.
    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, bit_valid, a_bit, b_bit, bit_first, bit_last, busy, word_count
    );
endinterface

// File: rtl/serializador_operandos.sv
// Operand serializer: takes a parallel operand pair and presents it LSB-first,
// one bit pair per beat, with first/last strobes for the downstream serial adder.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no word held, in_ready high, bit outputs forced to 0
// SHIFT | word in flight, current beat on a_bit/b_bit, busy high
module serializador_operandos #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serializador_operandos_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic [7:0]       word_cnt;

    logic shifting;
    logic is_last;
    logic consume;
    logic ready;
    logic accept;

    // Handshake decode and next-state selection.
    always_comb begin
        state_d  = state_q;
        shifting = (state_q == SHIFT);
        is_last  = shifting && (cnt == LAST_BEAT);
        consume  = shifting && bus.out_ready;
        // Ready on the consumed last beat is what allows zero-bubble reloads.
        ready    = !rst && (!shifting || (is_last && bus.out_ready));
        accept   = bus.in_valid && ready;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (consume && is_last) state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Shift registers, beat counter and completed-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            word_cnt <= '0;
        end else begin
            if (accept) begin
                a_sh <= bus.a_in;
                b_sh <= bus.b_in;
                cnt  <= '0;
            end else if (consume && !is_last) begin
                a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
            end
            if (consume && is_last) word_cnt <= word_cnt + 8'd1;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.bit_valid  = shifting;
    assign bus.busy       = shifting;
    assign bus.a_bit      = shifting && a_sh[0];
    assign bus.b_bit      = shifting && b_sh[0];
    assign bus.bit_first  = shifting && (cnt == '0);
    assign bus.bit_last   = is_last;
    assign bus.word_count = word_cnt;
endmodule

// File: tb/tb_serializador_operandos.sv
// Bench for the operand serializer: directed scenarios plus random traffic,
// checked by a scoreboard fed from accepted operand pairs.
module tb_serializador_operandos;
    localparam int W = 8;

    typedef struct packed {
        logic a;
        logic b;
        logic f;
        logic l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serializador_operandos_if #(.WIDTH(W)) bus ();

    serializador_operandos #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    n_chk   = 0;
    int    n_fail  = 0;
    int    n_words = 0;
    logic [7:0] exp_wc = 8'd0;
    int    ready_mode   = 0;
    logic  ready_script = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer side: out_ready always high, random, or scripted by the main sequence.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                2:       bus.out_ready = ready_script;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: compares every cycle against the queued expected beats.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            chk("ready_in_rst", 32'(bus.in_ready), 32'd0);
            q.delete();
            exp_wc = 8'd0;
        end else begin
            chk("word_count", 32'(bus.word_count), 32'(exp_wc));
            chk("bit_valid", 32'(bus.bit_valid), 32'(q.size() != 0));
            chk("busy", 32'(bus.busy), 32'(q.size() != 0));
            if (q.size() != 0) begin
                e = q[0];
                chk("a_bit", 32'(bus.a_bit), 32'(e.a));
                chk("b_bit", 32'(bus.b_bit), 32'(e.b));
                chk("bit_first", 32'(bus.bit_first), 32'(e.f));
                chk("bit_last", 32'(bus.bit_last), 32'(e.l));
                chk("in_ready_shift", 32'(bus.in_ready), 32'(e.l && bus.out_ready));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    if (e.l) exp_wc = exp_wc + 8'd1;
                end
            end else begin
                chk("idle_bits", 32'({bus.a_bit, bus.b_bit, bus.bit_first, bus.bit_last}), 32'd0);
                chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
            end
        end
    end

    // Offer a word starting just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                for (int i = 0; i < W; i++)
                    q.push_back('{a: a[i], b: b[i], f: (i == 0), l: (i == W - 1)});
                bus.in_valid = 1'b0;
                n_words++;
                return;
            end
        end
        chk("accept_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.bit_valid) return;
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wc", 32'(bus.word_count), 32'd0);
        chk("rst_valid", 32'(bus.bit_valid), 32'd0);
        step();

        // Reset at beat 4 of a word in flight: the word is dropped and not counted.
        send_word(8'hC3, 8'h5A);
        n_words--;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.bit_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_wc", 32'(bus.word_count), 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Basic word.
        send_word(8'h0F, 8'h01);
        drain();
        chk("basic_wc", 32'(bus.word_count), 32'd1);
        step();

        // Backpressure: three stall cycles while beat 2 is presented.
        send_word(8'hA5, 8'h3C);
        ready_mode = 2;
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            ready_script = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (!bus.bit_valid) break;
            cyc++;
            if (c >= 2 && c <= 4) begin
                chk("stall_a", 32'(bus.a_bit), 32'd1);
                chk("stall_b", 32'(bus.b_bit), 32'd1);
            end
            step();
        end
        chk("stall_cycles", 32'(cyc), 32'd11);
        ready_mode = 0;
        drain();
        step();

        // Back-to-back words with in_valid held across the boundary.
        send_word(8'hFF, 8'h00);
        send_word(8'hAA, 8'h55);
        drain();
        chk("b2b_wc", 32'(bus.word_count), 32'(n_words % 256));
        step();

        // Pulse in_valid at beat 3 of a word in flight: must be ignored.
        send_word(8'h96, 8'h69);
        repeat (3) step();
        bus.in_valid = 1'b1;
        bus.a_in     = 8'h12;
        bus.b_in     = 8'h34;
        @(negedge clk);
        chk("pulse_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.in_valid = 1'b0;
        drain();
        step();

        // 256 words back-to-back: the counter wraps back to its starting value.
        for (int i = 0; i < 256; i++) send_word(W'($urandom), W'($urandom));
        drain();
        chk("wrap_wc", 32'(bus.word_count), 32'(n_words % 256));
        step();

        // Random traffic with random consumer backpressure and idle gaps.
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send_word(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        drain();
        ready_mode = 0;
        step();
        @(negedge clk);
        chk("final_wc", 32'(bus.word_count), 32'(n_words % 256));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
